multi_abro: RTL and testbench

Parametrised N-channel event-join FSM: it asserts `z` for one cycle once every channel selected by `mask` has seen a 1, in any order, either simultaneously or in separate cycles, then re-arms. It generalises the two-input a/b join to N masked channels. It adds a synchronous abort and an optional collection timeout. It sits between event sources (handshake completions, sensor flags) and a controller that must wait for "all required events seen".

---
 rtl/multi_abro_pkg.sv | 23 ++
 rtl/multi_abro_tmr.sv | 32 +++
 rtl/multi_abro.sv | 160 ++++++++++++++++
 tb/tb_multi_abro.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_abro_pkg.sv
// multi_abro_pkg: shared state encoding, limits and the completion helper for
// the multi_abro event-join block.
// Build option: MULTI_ABRO_TIMEOUT_EN (enables the collection timeout).
package multi_abro_pkg;

    // Largest supported channel count.
    localparam int MULTI_ABRO_MAX_N = 32;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_TOUT    = 2'd3
    } multi_abro_state_e;

    // True when every required channel is present; an empty mask never completes.
    function automatic logic all_required(input logic [MULTI_ABRO_MAX_N-1:0] acc,
                                          input logic [MULTI_ABRO_MAX_N-1:0] msk);
        return (msk != 32'd0) && ((acc & msk) == msk);
    endfunction

endpackage

// File: rtl/multi_abro_tmr.sv
// multi_abro_tmr: saturating collection-cycle counter. It flags expiry when the
// count equals a non-zero limit. Only used when MULTI_ABRO_TIMEOUT_EN is defined.
module multi_abro_tmr #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [TW-1:0] i_limit,
    output logic          o_expired
);

    logic [TW-1:0] r_cnt;

    // Count collection cycles; hold at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= {TW{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {TW{1'b0}};
        end else if (i_inc && (r_cnt != {TW{1'b1}})) begin
            r_cnt <= r_cnt + {{(TW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // A zero limit disables expiry.
    assign o_expired = (i_limit != {TW{1'b0}}) && (r_cnt == i_limit);

endmodule

// File: rtl/multi_abro.sv
// multi_abro: N-channel masked event join. It pulses z for one cycle once every
// channel in mask has been seen, in any order, then re-arms. It supports a
// synchronous abort (clr) and an optional collection timeout.
// Build option: MULTI_ABRO_TIMEOUT_EN -- when undefined, timeout is ignored,
// COLLECT waits indefinitely and timed_out stays 0.
module multi_abro
    import multi_abro_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic [N-1:0]  ev,
    input  logic [N-1:0]  mask,
    input  logic [TW-1:0] timeout,
    output logic          z,
    output logic          timed_out,
    output logic          busy,
    output logic [N-1:0]  seen
);

    multi_abro_state_e r_state;
    logic [N-1:0]      r_seen;
    logic              r_z;
    logic              r_timed_out;
    logic              r_busy;

    logic [N-1:0]      w_hit;
    logic [N-1:0]      w_acc;
    logic              w_complete;
    logic              w_expired;

    // Qualify events by the live mask and decide completion.
    always_comb begin
        w_hit      = ev & mask;
        w_acc      = r_seen | w_hit;
        w_complete = all_required(MULTI_ABRO_MAX_N'(w_acc), MULTI_ABRO_MAX_N'(mask));
    end

`ifdef MULTI_ABRO_TIMEOUT_EN
    logic w_tmr_inc;
    logic w_tmr_clr;

    // Count only while entering or staying in COLLECT; clear otherwise.
    always_comb begin
        w_tmr_inc = 1'b0;
        if (clr) begin
            w_tmr_inc = 1'b0;
        end else if (r_state == ST_IDLE) begin
            w_tmr_inc = !w_complete && (w_hit != {N{1'b0}});
        end else if (r_state == ST_COLLECT) begin
            w_tmr_inc = !w_complete && !w_expired;
        end else begin
            w_tmr_inc = 1'b0;
        end
        w_tmr_clr = !w_tmr_inc;
    end

    multi_abro_tmr #(
        .TW (TW)
    ) u_tmr (
        .clk       (clk),
        .rst       (reset),
        .i_clr     (w_tmr_clr),
        .i_inc     (w_tmr_inc),
        .i_limit   (timeout),
        .o_expired (w_expired)
    );
`else
    logic w_unused_timeout;

    assign w_expired        = 1'b0;
    assign w_unused_timeout = ^timeout;
`endif

    // Join FSM: state, capture register and registered Moore outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_seen      <= {N{1'b0}};
            r_z         <= 1'b0;
            r_timed_out <= 1'b0;
            r_busy      <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_IDLE;
            r_seen      <= {N{1'b0}};
            r_z         <= 1'b0;
            r_timed_out <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_complete) begin
                        r_state     <= ST_DONE;
                        r_seen      <= r_seen;
                        r_z         <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_hit != {N{1'b0}}) begin
                        r_state     <= ST_COLLECT;
                        r_seen      <= w_hit;
                        r_z         <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_seen      <= {N{1'b0}};
                        r_z         <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (w_complete) begin
                        r_state     <= ST_DONE;
                        r_seen      <= r_seen;
                        r_z         <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (w_expired) begin
                        r_state     <= ST_TOUT;
                        r_seen      <= r_seen;
                        r_z         <= 1'b0;
                        r_timed_out <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state     <= ST_COLLECT;
                        r_seen      <= w_acc;
                        r_z         <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                ST_DONE, ST_TOUT: begin
                    // Events arriving here are dropped.
                    r_state     <= ST_IDLE;
                    r_seen      <= {N{1'b0}};
                    r_z         <= 1'b0;
                    r_timed_out <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_seen      <= {N{1'b0}};
                    r_z         <= 1'b0;
                    r_timed_out <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign z         = r_z;
    assign timed_out = r_timed_out;
    assign busy      = r_busy;
    assign seen      = r_seen;

endmodule

// File: tb/tb_multi_abro.sv
// tb_multi_abro: directed test-plan sequences with literal expectations, then
// randomized traffic checked every cycle against a behavioural join model.
module tb_multi_abro;

    localparam int N  = 4;
    localparam int TW = 8;
`ifdef MULTI_ABRO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          clr       = 1'b0;
    logic [N-1:0]  ev        = '0;
    logic [N-1:0]  mask      = '0;
    logic [TW-1:0] timeout   = '0;
    logic          z;
    logic          timed_out;
    logic          busy;
    logic [N-1:0]  seen;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    multi_abro #(.N(N), .TW(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .ev        (ev),
        .mask      (mask),
        .timeout   (timeout),
        .z         (z),
        .timed_out (timed_out),
        .busy      (busy),
        .seen      (seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 waiting, 1 collecting, 2 completion pulse, 3 timeout pulse
    int           m_phase = 0;
    logic [N-1:0] m_seen  = '0;
    int           m_len   = 0;   // cycles spent collecting so far

    function automatic int sat_len(input int len);
        int maxv;
        maxv = (1 << TW) - 1;
        return (len > maxv) ? maxv : len;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [N-1:0] hit;
        logic [N-1:0] acc;
        bit           all_in;
        if (reset || clr) begin
            m_phase = 0;
            m_seen  = '0;
            m_len   = 0;
        end else begin
            hit    = ev & mask;
            acc    = m_seen | hit;
            all_in = (mask != '0) && ((acc & mask) == mask);
            if (m_phase == 0) begin
                if (all_in) m_phase = 2;
                else if (hit != '0) begin
                    m_phase = 1;
                    m_seen  = hit;
                    m_len   = 1;
                end
            end else if (m_phase == 1) begin
                if (all_in) m_phase = 2;
                else if (TO_EN && (timeout != '0) && (sat_len(m_len) == int'(timeout))) m_phase = 3;
                else begin
                    m_seen = acc;
                    m_len  = m_len + 1;
                end
            end else begin
                m_phase = 0;
                m_seen  = '0;
                m_len   = 0;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (started) begin
            chk("model_z",         32'(z),         32'(m_phase == 2));
            chk("model_timed_out", 32'(timed_out), 32'(m_phase == 3));
            chk("model_busy",      32'(busy),      32'(m_phase == 1));
            chk("model_seen",      32'(seen),      32'(m_seen));
        end
    end

    task automatic cyc(input logic [N-1:0] e);
        ev = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_z", 32'(z), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        chk("rst_seen", 32'(seen), 32'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        started = 1'b1;

        // Test 1: separate events, any order
        mask = 4'b1111; timeout = 8'd0;
        cyc(4'b0001); chk("t1_busy", 32'(busy), 32'd1); chk("t1_seen0", 32'(seen), 32'h1);
        cyc(4'b0100); chk("t1_seen1", 32'(seen), 32'h5);
        cyc(4'b1000); chk("t1_seen2", 32'(seen), 32'hD);
        cyc(4'b0010); chk("t1_z", 32'(z), 32'd1); chk("t1_busy_done", 32'(busy), 32'd0);
        cyc(4'b0000); chk("t1_z_off", 32'(z), 32'd0); chk("t1_seen_clr", 32'(seen), 32'h0);

        // Test 2: simultaneous completion from idle
        mask = 4'b0110;
        cyc(4'b0110); chk("t2_z", 32'(z), 32'd1); chk("t2_busy", 32'(busy), 32'd0);
        cyc(4'b0000); chk("t2_z_off", 32'(z), 32'd0); chk("t2_busy2", 32'(busy), 32'd0);

        // Test 3: timeout with a missing channel
        mask = 4'b0011; timeout = 8'd3;
        cyc(4'b0001); chk("t3_busy1", 32'(busy), 32'd1);
        cyc(4'b0000); chk("t3_busy2", 32'(busy), 32'd1);
        cyc(4'b0000); chk("t3_busy3", 32'(busy), 32'd1);
        cyc(4'b0000);
        chk("t3_tout", 32'(timed_out), 32'(TO_EN));
        chk("t3_busy4", 32'(busy), 32'(!TO_EN));
        chk("t3_z", 32'(z), 32'd0);
        cyc(4'b0000);
        chk("t3_tout_off", 32'(timed_out), 32'd0);
        chk("t3_seen", 32'(seen), TO_EN ? 32'h0 : 32'h1);
        clr = 1'b1; cyc(4'b0000); clr = 1'b0;

        // Test 4: final event on the expiry edge, completion wins
        cyc(4'b0001);
        cyc(4'b0000);
        cyc(4'b0000);
        cyc(4'b0010); chk("t4_z", 32'(z), 32'd1); chk("t4_tout", 32'(timed_out), 32'd0);
        cyc(4'b0000);

        // Test 5: clr in COLLECT, then reset mid-collection
        mask = 4'b1111; timeout = 8'd0;
        cyc(4'b0001);
        cyc(4'b0100); chk("t5_seen", 32'(seen), 32'h5);
        clr = 1'b1; cyc(4'b0000); clr = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0); chk("t5_seen_clr", 32'(seen), 32'h0); chk("t5_z", 32'(z), 32'd0);
        cyc(4'b0011); chk("t5_busy2", 32'(busy), 32'd1);
        ev = 4'b0000;
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0); chk("t5_rst_seen", 32'(seen), 32'h0);
        chk("t5_rst_z", 32'(z), 32'd0); chk("t5_rst_tout", 32'(timed_out), 32'd0);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // Test 6: empty mask never leaves idle
        mask = 4'b0000; timeout = 8'd2;
        for (int i = 0; i < 50; i++) begin
            cyc(4'($urandom_range(0, 15)));
            chk("t6_z", 32'(z), 32'd0);
            chk("t6_busy", 32'(busy), 32'd0);
            chk("t6_tout", 32'(timed_out), 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) timeout = 8'($urandom_range(0, 6));
            clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                cyc(4'b0000);
                reset = 1'b0;
            end else begin
                cyc(4'(($urandom_range(0, 3) == 0 ? 1 : 0)
                     | ($urandom_range(0, 3) == 0 ? 2 : 0)
                     | ($urandom_range(0, 3) == 0 ? 4 : 0)
                     | ($urandom_range(0, 3) == 0 ? 8 : 0)));
            end
        end
        clr = 1'b0;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
